// File: rtl/wb_data_stage_v2_if.sv
// wb_data_stage_v2_if: handshaked data-cache port between the write-back stage and the cache
//   master (stage): c_req, c_we, c_be, c_addr, c_wdata out; c_ready, c_rvalid, c_rdata, c_miss in
//   slave (cache): the mirror image
interface wb_data_stage_v2_if #(parameter int XLEN = 32, parameter int ADDR_W = 32);
  logic c_req;
  logic c_we;
  logic [XLEN/8-1:0] c_be;
  logic [ADDR_W-1:0] c_addr;
  logic [XLEN-1:0] c_wdata;
  logic c_ready;
  logic c_rvalid;
  logic [XLEN-1:0] c_rdata;
  logic c_miss;
  modport master(output c_req, c_we, c_be, c_addr, c_wdata, input c_ready, c_rvalid, c_rdata, c_miss);
  modport slave(input c_req, c_we, c_be, c_addr, c_wdata, output c_ready, c_rvalid, c_rdata, c_miss);
endinterface

// File: rtl/wb_data_stage_v2.sv
// wb_data_stage_v2: write-back data stage with handshaked cache port, load extension and misalign trap
//   in: clk, rst (async, active-high), bubbleW, flushW, mem_rd, mem_wr, mem_type (funct3), addr, wr_data
//   c (master): cache request/response port
//   out: data_WB, stall_req, misalign (1-cycle pulse), rd_count, wr_count, miss_count
//   WB_PERF_CNT_EN: when defined the perf counters are built, otherwise they read 0
module wb_data_stage_v2 #(
  parameter int XLEN = 32,
  parameter int ADDR_W = 32,
  parameter int CNT_W = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic bubbleW,
  input  logic flushW,
  input  logic mem_rd,
  input  logic mem_wr,
  input  logic [2:0] mem_type,
  input  logic [ADDR_W-1:0] addr,
  input  logic [XLEN-1:0] wr_data,
  wb_data_stage_v2_if.master c,
  output logic [XLEN-1:0] data_WB,
  output logic stall_req,
  output logic misalign,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count,
  output logic [CNT_W-1:0] miss_count
);
  localparam int BW = XLEN / 8;
  localparam int LW = $clog2(BW);
  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;
  state_t state;
  logic [2:0] op_type;
  logic op_we;
  logic [ADDR_W-1:0] op_addr;
  logic [XLEN-1:0] op_wdata;
  logic idle, take, mem, mis, start, acc, cur_we;
  logic [2:0] cur_type;
  logic [ADDR_W-1:0] cur_addr;
  logic [XLEN-1:0] cur_wdata, s, ext;
  logic [LW-1:0] lo;
  logic [BW-1:0] mask;
  assign idle = state == IDLE;
  assign take = idle & !bubbleW & !flushW;
  assign mem = mem_rd | mem_wr;
  assign mis = (mem_type[1:0] == 2'd1 & addr[0]) | (mem_type[1:0] == 2'd2 & |addr[1:0]) |
               (mem_type[1:0] == 2'd3 & |addr[2:0]);
  assign start = take & mem & !mis;
  // In IDLE the request is driven straight from the pipeline; afterwards from the latched op
  assign cur_type = idle ? mem_type : op_type;
  assign cur_we = idle ? mem_wr : op_we;
  assign cur_addr = idle ? addr : op_addr;
  assign cur_wdata = idle ? wr_data : op_wdata;
  assign lo = cur_addr[LW-1:0];
  assign mask = cur_type[1:0] == 2'd0 ? BW'(1) : cur_type[1:0] == 2'd1 ? BW'(3) :
                cur_type[1:0] == 2'd2 ? BW'(15) : BW'(255);
  assign c.c_req = start | state == REQ;
  assign c.c_we = cur_we;
  assign c.c_addr = cur_addr & ~ADDR_W'(BW - 1);
  assign c.c_be = mask << lo;
  assign c.c_wdata = cur_wdata << {lo, 3'b000};
  assign acc = c.c_req & c.c_ready;
  assign stall_req = (start & !(mem_wr & c.c_ready)) | state == REQ | (state == RSP & !c.c_rvalid);
  assign s = c.c_rdata >> {lo, 3'b000};
  assign ext = cur_type == 3'b000 ? XLEN'($signed(s[7:0])) :
               cur_type == 3'b001 ? XLEN'($signed(s[15:0])) :
               cur_type == 3'b010 ? XLEN'($signed(s[31:0])) :
               cur_type == 3'b100 ? XLEN'(s[7:0]) :
               cur_type == 3'b101 ? XLEN'(s[15:0]) :
               cur_type == 3'b110 ? XLEN'(s[31:0]) : s;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      data_WB <= '0;
      misalign <= 1'b0;
      op_type <= '0;
      op_we <= 1'b0;
      op_addr <= '0;
      op_wdata <= '0;
    end else begin
      misalign <= take & mem & mis;
      case (state)
        IDLE: if (!bubbleW) begin
          if (flushW || (mem && mis)) data_WB <= '0;
          else if (!mem) data_WB <= XLEN'(addr);
          else begin
            op_type <= mem_type;
            op_we <= mem_wr;
            op_addr <= addr;
            op_wdata <= wr_data;
            state <= !c.c_ready ? REQ : mem_wr ? IDLE : RSP;
          end
        end
        REQ: if (c.c_ready) state <= op_we ? IDLE : RSP;
        RSP: if (c.c_rvalid) begin
          data_WB <= ext;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef WB_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count <= '0;
      wr_count <= '0;
      miss_count <= '0;
    end else begin
      rd_count <= rd_count + CNT_W'(acc & !cur_we);
      wr_count <= wr_count + CNT_W'(acc & cur_we);
      miss_count <= miss_count + CNT_W'(acc & c.c_miss);
    end
  end
`else
  assign rd_count = '0;
  assign wr_count = '0;
  assign miss_count = '0;
`endif
endmodule
